// File: rtl/sd_crc_engine_pkg.sv
// sd_crc_pkg: shared FSM state, SD CRC polynomials and the serial CRC step.
package sd_crc_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  function automatic logic [63:0] crc_step(input logic [63:0] crc, input logic d,
                                           input logic [63:0] poly, input int unsigned w);
    logic fb;
    fb = crc[6'(w - 1)] ^ d;
    return ((crc << 1) ^ (fb ? poly : 64'd0)) & ((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/sd_crc_engine_if.sv
// sd_crc_engine_if: start/stream/result bundle of the SD CRC engine.
interface sd_crc_engine_if #(parameter int CRC_W = 7, parameter int DATA_W = 8);
  logic start, s_valid, s_ready, s_last, done, match, busy;
  logic [DATA_W-1:0] s_data;
  logic [CRC_W-1:0] exp_crc, crc_out;
  modport master(output start, s_valid, s_data, s_last, exp_crc,
                 input s_ready, crc_out, done, match, busy);
  modport slave(input start, s_valid, s_data, s_last, exp_crc,
                output s_ready, crc_out, done, match, busy);
endinterface

// File: rtl/sd_crc_lfsr_comb.sv
// sd_crc_lfsr_comb: DATA_W serial CRC steps unrolled into one combinational network, MSB first.
module sd_crc_lfsr_comb import sd_crc_pkg::*; #(
  parameter int CRC_W = 7,
  parameter logic [CRC_W-1:0] POLY = CRC_W'(CRC7_POLY),
  parameter int DATA_W = 8
) (
  input  logic [CRC_W-1:0]  i_crc,
  input  logic [DATA_W-1:0] i_data,
  output logic [CRC_W-1:0]  o_crc
);
  logic [CRC_W-1:0] w_acc;
  always_comb begin
    w_acc = i_crc;
    for (int i = DATA_W - 1; i >= 0; i--)
      w_acc = CRC_W'(crc_step(64'(w_acc), i_data[i], 64'(POLY), CRC_W));
  end
  assign o_crc = w_acc;
endmodule

// File: rtl/sd_crc_engine.sv
// sd_crc_engine: framed streaming CRC generator/checker with compare-against-expected result.
module sd_crc_engine import sd_crc_pkg::*; #(
  parameter int CRC_W = 7,
  parameter logic [CRC_W-1:0] POLY = CRC_W'(CRC7_POLY),
  parameter logic [CRC_W-1:0] INIT = '0,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst,
  sd_crc_engine_if.slave bus
);
  state_t r_state, w_next;
  logic [CRC_W-1:0] r_crc, w_crc_next;
  logic r_match, w_hs;
  sd_crc_lfsr_comb #(.CRC_W(CRC_W), .POLY(POLY), .DATA_W(DATA_W)) u_lfsr (
    .i_crc(r_crc), .i_data(bus.s_data), .o_crc(w_crc_next)
  );
  assign bus.s_ready = (r_state == RUN) && !bus.start;
  assign w_hs = bus.s_valid && bus.s_ready;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = bus.start ? RUN : IDLE;
      RUN:  w_next = (w_hs && bus.s_last) ? DONE : RUN;
      default: w_next = bus.start ? RUN : IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // match is resolved on the last-beat edge so it is already valid during the done cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_crc <= INIT;
      r_match <= 1'b0;
    end else if (bus.start) begin
      r_crc <= INIT;
      r_match <= 1'b0;
    end else if (w_hs) begin
      r_crc <= w_crc_next;
      if (bus.s_last) r_match <= (w_crc_next == bus.exp_crc);
    end
  assign bus.crc_out = r_crc;
  assign bus.match = r_match;
  assign bus.done = (r_state == DONE);
  assign bus.busy = (r_state != IDLE);
endmodule
